// File: rtl/cnoc_indication_deframer.sv
// rtl/cnoc_indication_deframer.sv - reassembles framed CNoC indication words into wide message records
module cnoc_indication_deframer #(
   parameter int MAX_PAYLOAD = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [31:0]              in_first,
   input  logic                     in_avail,
   output logic                     in_deq,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [15:0]              out_portal,
   output logic [15:0]              out_method,
   output logic [15:0]              out_words,
   output logic [32*MAX_PAYLOAD-1:0] out_payload,
   output logic                     out_overflow,
   output logic                     out_mismatch,
   output logic [15:0]              msg_count
);

   typedef enum logic [1:0] {
      ST_PORTAL  = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_PRESENT = 2'd3
   } state_t;

   state_t                   r_state;
   logic                     r_valid;
   logic [15:0]              r_portal;
   logic [15:0]              r_plen;
   logic [15:0]              r_method;
   logic [15:0]              r_words;
   logic [32*MAX_PAYLOAD-1:0] r_payload;
   logic                     r_overflow;
   logic                     r_mismatch;
   logic [15:0]              r_remaining;
   logic [15:0]              r_idx;
   logic [15:0]              r_msg_count;

   logic [15:0]              w_hlen;
   logic [15:0]              w_words;
   logic [15:0]              w_plen_m1;
   logic                     w_deq;

   // Header-derived quantities; the header length is authoritative for how many payload words follow.
   always_comb begin
      w_hlen    = in_first[15:0];
      w_words   = (w_hlen == 16'd0) ? 16'd0 : (w_hlen - 16'd1);
      w_plen_m1 = r_plen - 16'd1;
      w_deq     = in_avail && (r_state != ST_PRESENT);
   end

   // Framing state machine: one word consumed per cycle while parsing, stall while presenting.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state     <= ST_PORTAL;
         r_valid     <= 1'b0;
         r_portal    <= '0;
         r_plen      <= '0;
         r_method    <= '0;
         r_words     <= '0;
         r_payload   <= '0;
         r_overflow  <= 1'b0;
         r_mismatch  <= 1'b0;
         r_remaining <= '0;
         r_idx       <= '0;
         r_msg_count <= '0;
      end else begin
         case (r_state)
            ST_PORTAL: begin
               if (in_avail) begin
                  r_payload  <= '0;
                  r_overflow <= 1'b0;
                  r_mismatch <= 1'b0;
                  r_portal   <= in_first[31:16];
                  r_plen     <= in_first[15:0];
                  r_state    <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (in_avail) begin
                  r_method    <= in_first[31:16];
                  r_mismatch  <= (w_hlen != w_plen_m1);
                  r_words     <= w_words;
                  r_remaining <= w_words;
                  r_idx       <= '0;
                  if (w_words == 16'd0) begin
                     r_state <= ST_PRESENT;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (in_avail) begin
                  for (int k = 0; k < MAX_PAYLOAD; k++) begin
                     if (r_idx == 16'(k)) begin
                        r_payload[32*k +: 32] <= in_first;
                     end
                  end
                  // Words beyond storage are still consumed so the stream stays aligned.
                  if (r_idx >= 16'(MAX_PAYLOAD)) begin
                     r_overflow <= 1'b1;
                  end
                  if (r_idx != 16'hFFFF) begin
                     r_idx <= r_idx + 16'd1;
                  end
                  r_remaining <= r_remaining - 16'd1;
                  if (r_remaining == 16'd1) begin
                     r_state <= ST_PRESENT;
                     r_valid <= 1'b1;
                  end
               end
            end
            ST_PRESENT: begin
               if (out_ready) begin
                  r_valid     <= 1'b0;
                  r_state     <= ST_PORTAL;
                  r_msg_count <= r_msg_count + 16'd1;
               end
            end
            default: begin
               r_state <= ST_PORTAL;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_deq       = w_deq;
   assign out_valid    = r_valid;
   assign out_portal   = r_portal;
   assign out_method   = r_method;
   assign out_words    = r_words;
   assign out_payload  = r_payload;
   assign out_overflow = r_overflow;
   assign out_mismatch = r_mismatch;
   assign msg_count    = r_msg_count;

endmodule
